// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 64;

  // Ceiling log2 that is usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port DATA_W x DEPTH storage with a registered, enabled read port.
// Latency: write visible at the next edge; read data valid one edge after rd_en.
// Backpressure: none; the controller only issues accepted accesses.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately unreset so it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address read during write returns the old word (pass-through at full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock circular FIFO with thresholds, sticky error flags and sync clear.
// Latency: write readable one edge later; read data/rd_valid one edge after rd_acc.
// Backpressure: writes dropped when full unless a read is accepted the same cycle.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  AF_LEVEL = DEPTH - 4,
  parameter int  AE_LEVEL = 4,
  localparam int CNT_W    = clog2(DEPTH) + 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end
  if (DATA_W < 1) begin : g_bad_dw
    $error("sync_fifo_param: DATA_W must be at least 1");
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_acc, rd_acc;

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  // clr blocks both ports so a clearing cycle neither moves data nor flags errors.
  assign rd_acc = rd_en && !empty && !clr;
  assign wr_acc = wr_en && (!full || rd_acc) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && empty)   underflow <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and randomized bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;

  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int AF  = 6;
  localparam int AE  = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n, clr, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic          m_of, m_uf, m_rv;
  logic [DW-1:0] m_rd;

  sync_fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"},    32'(count),        32'(q.size()));
    chk({tag, ".empty"},    32'(empty),        32'(q.size() == 0));
    chk({tag, ".full"},     32'(full),         32'(q.size() == DEP));
    chk({tag, ".a_empty"},  32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, ".a_full"},   32'(almost_full),  32'(q.size() >= AF));
    chk({tag, ".overflow"}, 32'(overflow),     32'(m_of));
    chk({tag, ".underflow"},32'(underflow),    32'(m_uf));
    chk({tag, ".rd_valid"}, 32'(rd_valid),     32'(m_rv));
    chk({tag, ".rd_data"},  32'(rd_data),      32'(m_rd));
  endtask

  task automatic model_reset();
    q.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
    m_rv = 1'b0;
    m_rd = '0;
  endtask

  // One clock of traffic: drive at negedge, apply FIFO rules to the model at the edge, check after.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c,
                      input string tag);
    bit was_full, was_empty, racc, wacc;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge clk);
    was_full  = (q.size() == DEP);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_of = 1'b0;
      m_uf = 1'b0;
      m_rv = 1'b0;
    end else begin
      racc = r && !was_empty;
      wacc = w && (!was_full || racc);
      if (r && was_empty) m_uf = 1'b1;
      if (w && !wacc)     m_of = 1'b1;
      m_rv = racc;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(d);
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_all("reset");
    rst_n = 1'b1;

    // Basic write then read-out in order.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, "wr4");
    chk("wr4.count_lit", 32'(count), 32'd4);
    chk("wr4.ae_lit", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, "rd4");
      chk("rd4.data_lit", 32'(rd_data), 32'h11 + 32'(i));
      chk("rd4.vld_lit", 32'(rd_valid), 32'd1);
    end
    step(1'b0, '0, 1'b0, 1'b0, "idle");
    chk("idle.empty_lit", 32'(empty), 32'd1);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEP; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, "fill");
    step(1'b1, 8'hEE, 1'b0, 1'b0, "ovf");
    chk("ovf.flag_lit", 32'(overflow), 32'd1);
    chk("ovf.count_lit", 32'(count), 32'd8);
    for (int i = 0; i < DEP; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, "drain");
      chk("drain.data_lit", 32'(rd_data), 32'h20 + 32'(i));
    end

    // Pass-through at full.
    step(1'b0, '0, 1'b0, 1'b1, "clr1");
    for (int i = 0; i < DEP; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, "fill2");
    step(1'b1, 8'hAA, 1'b1, 1'b0, "pass");
    chk("pass.count_lit", 32'(count), 32'd8);
    chk("pass.ovf_lit", 32'(overflow), 32'd0);
    for (int i = 0; i < DEP; i++) step(1'b0, '0, 1'b1, 1'b0, "drain2");
    chk("drain2.last_lit", 32'(rd_data), 32'hAA);

    // Write+read at empty: write only, underflow raised.
    step(1'b1, 8'h55, 1'b1, 1'b0, "wr_rd_empty");
    chk("wre.count_lit", 32'(count), 32'd1);
    chk("wre.uf_lit", 32'(underflow), 32'd1);
    chk("wre.vld_lit", 32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, "rd55");
    chk("rd55.data_lit", 32'(rd_data), 32'h55);

    // Streaming with pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, "prime");
    for (int i = 0; i < 20; i++) step(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0, "stream");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "flush");

    // Clear with 5 entries and a pending write and read.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, "five");
    step(1'b1, 8'h77, 1'b1, 1'b1, "clr5");
    chk("clr5.count_lit", 32'(count), 32'd0);
    chk("clr5.uf_lit", 32'(underflow), 32'd0);

    // Randomized traffic: write-heavy, read-heavy, then balanced.
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = (i < 200) ? 80 : (i < 400) ? 25 : 55;
      rp = (i < 200) ? 25 : (i < 400) ? 80 : 55;
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) < 2, "rand");
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0, "burst");
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hC3;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("arst");
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk_all("arst_hold");
    rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0, "post_rst_wr");
    step(1'b0, '0, 1'b1, 1'b0, "post_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
